// File: rtl/trap_sequencer.sv
// Trap commit sequencer: waits for the data bus to drain, then commits one trap
// (flush, redirect, CP0 strobes) in a single cycle and holds off new traps during refill.
module trap_sequencer #(
  parameter int DRAIN_MAX     = 16,
  parameter int REFILL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_exc_valid,
  input  logic [31:0] i_exc_type,
  input  logic [31:0] i_exc_target,
  input  logic [31:0] i_exc_pc,
  input  logic        i_exc_in_ds,
  input  logic [31:0] i_exc_badvaddr,
  input  logic        i_mem_busy,
  output logic        o_pipe_stall,
  output logic        o_flush_all,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_cp0_epc_we,
  output logic [31:0] o_cp0_epc_wdata,
  output logic        o_cp0_cause_we,
  output logic [4:0]  o_cp0_exccode,
  output logic        o_cp0_bd,
  output logic        o_cp0_exl_set,
  output logic        o_cp0_exl_clr,
  output logic        o_cp0_badvaddr_we,
  output logic [31:0] o_cp0_badvaddr_wdata,
  output logic        o_busy,
  output logic        o_drain_timeout
);

  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam int RW = (REFILL_CYCLES > 0) ? $clog2(REFILL_CYCLES + 1) : 1;

  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_COMMIT,
    S_RECOVER
  } state_t;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [DW-1:0]   r_drain_cnt;
  logic [DW-1:0]   w_nxt_drain_cnt;
  logic [RW-1:0]   r_refill_cnt;
  logic [RW-1:0]   w_nxt_refill_cnt;

  // Trap captured on acceptance
  logic [31:0]     r_type;
  logic [31:0]     r_target;
  logic [31:0]     r_pc;
  logic            r_in_ds;
  logic [31:0]     r_badvaddr;

  // Registered outputs
  logic            r_pipe_stall;
  logic            r_flush_all;
  logic            r_redirect_valid;
  logic [31:0]     r_redirect_pc;
  logic            r_epc_we;
  logic [31:0]     r_epc_wdata;
  logic            r_cause_we;
  logic [4:0]      r_exccode;
  logic            r_bd;
  logic            r_exl_set;
  logic            r_exl_clr;
  logic            r_badvaddr_we;
  logic [31:0]     r_badvaddr_wdata;
  logic            r_busy;
  logic            r_drain_timeout;

  logic            w_accept;
  logic            w_force;
  logic            w_commit;
  logic            w_is_eret;
  logic            w_is_addr_err;
  logic [31:0]     w_type;
  logic [31:0]     w_target;
  logic [31:0]     w_pc;
  logic            w_in_ds;
  logic [31:0]     w_badvaddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_nxt_state      = r_state;
    w_nxt_drain_cnt  = r_drain_cnt;
    w_nxt_refill_cnt = r_refill_cnt;
    w_force          = 1'b0;
    w_accept         = (r_state == S_IDLE) && i_exc_valid && (i_exc_type != '0);

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt_state     = i_mem_busy ? S_DRAIN : S_COMMIT;
          w_nxt_drain_cnt = '0;
        end
      end
      S_DRAIN: begin
        if (!i_mem_busy) begin
          w_nxt_state = S_COMMIT;
        end else if (r_drain_cnt == DW'(DRAIN_MAX - 1)) begin
          w_nxt_state = S_COMMIT;
          w_force     = 1'b1;
        end else begin
          w_nxt_drain_cnt = r_drain_cnt + DW'(1);
        end
      end
      S_COMMIT: begin
        w_nxt_state      = (REFILL_CYCLES == 0) ? S_IDLE : S_RECOVER;
        w_nxt_refill_cnt = '0;
      end
      S_RECOVER: begin
        if (r_refill_cnt == RW'(REFILL_CYCLES - 1)) w_nxt_state = S_IDLE;
        else                                       w_nxt_refill_cnt = r_refill_cnt + RW'(1);
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // A trap that commits straight from IDLE has not been latched yet, so use the live inputs.
  always_comb begin
    w_type        = w_accept ? i_exc_type     : r_type;
    w_target      = w_accept ? i_exc_target   : r_target;
    w_pc          = w_accept ? i_exc_pc       : r_pc;
    w_in_ds       = w_accept ? i_exc_in_ds    : r_in_ds;
    w_badvaddr    = w_accept ? i_exc_badvaddr : r_badvaddr;
    w_commit      = (w_nxt_state == S_COMMIT);
    w_is_eret     = (w_type == EXC_ERET);
    w_is_addr_err = (w_type == EXC_ADEL) || (w_type == EXC_ADES);
  end

  // Data fields are zero whenever their strobe is low, so idle buses stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_cnt      <= '0;
      r_refill_cnt     <= '0;
      r_type           <= '0;
      r_target         <= '0;
      r_pc             <= '0;
      r_in_ds          <= 1'b0;
      r_badvaddr       <= '0;
      r_pipe_stall     <= 1'b0;
      r_flush_all      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_epc_we         <= 1'b0;
      r_epc_wdata      <= '0;
      r_cause_we       <= 1'b0;
      r_exccode        <= '0;
      r_bd             <= 1'b0;
      r_exl_set        <= 1'b0;
      r_exl_clr        <= 1'b0;
      r_badvaddr_we    <= 1'b0;
      r_badvaddr_wdata <= '0;
      r_busy           <= 1'b0;
      r_drain_timeout  <= 1'b0;
    end else begin
      r_drain_cnt  <= w_nxt_drain_cnt;
      r_refill_cnt <= w_nxt_refill_cnt;
      if (w_accept) begin
        r_type     <= i_exc_type;
        r_target   <= i_exc_target;
        r_pc       <= i_exc_pc;
        r_in_ds    <= i_exc_in_ds;
        r_badvaddr <= i_exc_badvaddr;
      end
      r_pipe_stall     <= (w_nxt_state == S_DRAIN);
      r_flush_all      <= w_commit;
      r_redirect_valid <= w_commit;
      r_redirect_pc    <= w_commit ? w_target : '0;
      r_epc_we         <= w_commit && !w_is_eret;
      r_epc_wdata      <= (w_commit && !w_is_eret) ? (w_in_ds ? w_pc - 32'd4 : w_pc) : '0;
      r_cause_we       <= w_commit && !w_is_eret;
      r_exccode        <= (w_commit && !w_is_eret) ? w_type[4:0] : '0;
      r_bd             <= w_commit && !w_is_eret && w_in_ds;
      r_exl_set        <= w_commit && !w_is_eret;
      r_exl_clr        <= w_commit && w_is_eret;
      r_badvaddr_we    <= w_commit && w_is_addr_err;
      r_badvaddr_wdata <= (w_commit && w_is_addr_err) ? w_badvaddr : '0;
      r_busy           <= (w_nxt_state != S_IDLE);
      r_drain_timeout  <= r_drain_timeout | w_force;
    end
  end

  assign o_pipe_stall         = r_pipe_stall;
  assign o_flush_all          = r_flush_all;
  assign o_redirect_valid     = r_redirect_valid;
  assign o_redirect_pc        = r_redirect_pc;
  assign o_cp0_epc_we         = r_epc_we;
  assign o_cp0_epc_wdata      = r_epc_wdata;
  assign o_cp0_cause_we       = r_cause_we;
  assign o_cp0_exccode        = r_exccode;
  assign o_cp0_bd             = r_bd;
  assign o_cp0_exl_set        = r_exl_set;
  assign o_cp0_exl_clr        = r_exl_clr;
  assign o_cp0_badvaddr_we    = r_badvaddr_we;
  assign o_cp0_badvaddr_wdata = r_badvaddr_wdata;
  assign o_busy               = r_busy;
  assign o_drain_timeout      = r_drain_timeout;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: table of directed traps, randomized traps against a
// transaction-level schedule model, plus reset-in-commit and held-request sequences.
module tb_trap_sequencer;

  localparam int DRAIN_MAX = 16;
  localparam int REFILL    = 3;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic        epc_we;
    logic [31:0] epc;
    logic        cause_we;
    logic [4:0]  code;
    logic        bd;
    logic        exl_set;
    logic        exl_clr;
    logic        bva_we;
    logic [31:0] bva;
    logic        busy;
    logic        timeout;
  } out_t;

  typedef struct packed {
    logic [31:0] ty;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bva;
    logic [7:0]  busy_len;  // edges mem_busy stays high, counting the accept edge
  } trap_t;

  typedef struct {
    string name;
    trap_t tr;
    int    stall;
    bit    forced;
    out_t  commit;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, exc_in_ds, mem_busy;
  logic [31:0] exc_type, exc_target, exc_pc, exc_badvaddr;
  logic        pipe_stall, flush_all, redirect_valid, cp0_epc_we, cp0_cause_we, cp0_bd;
  logic        cp0_exl_set, cp0_exl_clr, cp0_badvaddr_we, busy, drain_timeout;
  logic [31:0] redirect_pc, cp0_epc_wdata, cp0_badvaddr_wdata;
  logic [4:0]  cp0_exccode;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_timeout = 1'b0;
  logic [31:0] types [8] = '{32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0a, 32'h0c, 32'h0e};

  always #5 clk = ~clk;

  trap_sequencer #(.DRAIN_MAX(DRAIN_MAX), .REFILL_CYCLES(REFILL)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_exc_valid          (exc_valid),
    .i_exc_type           (exc_type),
    .i_exc_target         (exc_target),
    .i_exc_pc             (exc_pc),
    .i_exc_in_ds          (exc_in_ds),
    .i_exc_badvaddr       (exc_badvaddr),
    .i_mem_busy           (mem_busy),
    .o_pipe_stall         (pipe_stall),
    .o_flush_all          (flush_all),
    .o_redirect_valid     (redirect_valid),
    .o_redirect_pc        (redirect_pc),
    .o_cp0_epc_we         (cp0_epc_we),
    .o_cp0_epc_wdata      (cp0_epc_wdata),
    .o_cp0_cause_we       (cp0_cause_we),
    .o_cp0_exccode        (cp0_exccode),
    .o_cp0_bd             (cp0_bd),
    .o_cp0_exl_set        (cp0_exl_set),
    .o_cp0_exl_clr        (cp0_exl_clr),
    .o_cp0_badvaddr_we    (cp0_badvaddr_we),
    .o_cp0_badvaddr_wdata (cp0_badvaddr_wdata),
    .o_busy               (busy),
    .o_drain_timeout      (drain_timeout)
  );

  function automatic out_t got();
    out_t o;
    o = '{pipe_stall, flush_all, redirect_valid, redirect_pc, cp0_epc_we, cp0_epc_wdata,
          cp0_cause_we, cp0_exccode, cp0_bd, cp0_exl_set, cp0_exl_clr, cp0_badvaddr_we,
          cp0_badvaddr_wdata, busy, drain_timeout};
    return o;
  endfunction

  function automatic trap_t mk_trap(logic [31:0] ty, logic [31:0] tgt, logic [31:0] pc,
                                    logic ds, logic [31:0] bva, int len);
    trap_t t;
    t = '{ty, tgt, pc, ds, bva, 8'(len)};
    return t;
  endfunction

  // Hand-written commit expectation for the directed table
  function automatic out_t mk_commit(logic [31:0] tgt, logic epc_we, logic [31:0] epc, logic [4:0] code,
                                     logic bd, logic exl_set, logic exl_clr, logic bva_we, logic [31:0] bva);
    out_t o;
    o = '0;
    o.flush = 1'b1;  o.rv = 1'b1;  o.rpc = tgt;  o.busy = 1'b1;
    o.epc_we = epc_we;  o.epc = epc;  o.cause_we = epc_we;  o.code = code;  o.bd = bd;
    o.exl_set = exl_set;  o.exl_clr = exl_clr;  o.bva_we = bva_we;  o.bva = bva;
    return o;
  endfunction

  // Reference: the commit a trap must produce, straight from the trap rules
  function automatic out_t model_commit(trap_t t);
    out_t o;
    o = '0;
    o.flush = 1'b1;  o.rv = 1'b1;  o.rpc = t.tgt;  o.busy = 1'b1;
    if (t.ty == 32'h0e) begin
      o.exl_clr = 1'b1;
    end else begin
      o.epc_we   = 1'b1;
      o.epc      = t.ds ? t.pc - 32'd4 : t.pc;
      o.cause_we = 1'b1;
      o.code     = t.ty[4:0];
      o.bd       = t.ds;
      o.exl_set  = 1'b1;
      if (t.ty == 32'h04 || t.ty == 32'h05) begin
        o.bva_we = 1'b1;
        o.bva    = t.bva;
      end
    end
    return o;
  endfunction

  function automatic out_t quiet_out(logic is_busy, logic is_stall);
    out_t o;
    o = '0;
    o.busy = is_busy;  o.stall = is_stall;  o.timeout = exp_timeout;
    return o;
  endfunction

  task automatic check(input string name, input int cyc, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_trap(input trap_t t);
    exc_valid = 1'b1;  exc_type = t.ty;  exc_target = t.tgt;
    exc_pc = t.pc;  exc_in_ds = t.ds;  exc_badvaddr = t.bva;
  endtask

  task automatic drive_noise();
    exc_valid = 1'($urandom_range(0, 1));
    exc_type = types[$urandom_range(0, 7)];
    exc_target = $urandom;  exc_pc = $urandom;
    exc_in_ds = 1'($urandom_range(0, 1));  exc_badvaddr = $urandom;
  endtask

  // Idle cycles with either no request or a type-0 request, which must be ignored
  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      drive_noise();
      exc_type = '0;
      mem_busy = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check(name, i, got(), quiet_out(1'b0, 1'b0));
    end
    exc_valid = 1'b0;
  endtask

  // One trap: outputs after accept edge t+j are DRAIN for j<stall, COMMIT at j=stall,
  // RECOVER for REFILL cycles, then IDLE.
  task automatic run_trap(input trap_t t, input out_t commit, input int stall, input bit forced,
                          input bit hold, input string name);
    out_t e;
    drive_trap(t);
    mem_busy = (t.busy_len > 0);
    for (int j = 0; j <= stall + REFILL + 1; j++) begin
      @(posedge clk); #1;
      if (j < stall) begin
        e = quiet_out(1'b1, 1'b1);
      end else if (j == stall) begin
        if (forced) exp_timeout = 1'b1;
        e = commit;
        e.timeout = exp_timeout;
      end else if (j <= stall + REFILL) begin
        e = quiet_out(1'b1, 1'b0);
      end else begin
        e = quiet_out(1'b0, 1'b0);
      end
      check(name, j, got(), e);
      mem_busy = (j + 1 < int'(t.busy_len));
      if (hold) drive_trap(t);
      else      drive_noise();
    end
    if (!hold) exc_valid = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{"sys",      mk_trap(32'h08, 32'hbfc00380, 32'h80001000, 1'b0, 32'h0, 0), 0, 1'b0,
                mk_commit(32'hbfc00380, 1'b1, 32'h80001000, 5'h08, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0)};
    vecs[1] = '{"adel_ds",  mk_trap(32'h04, 32'hbfc00380, 32'h80002004, 1'b1, 32'h3, 4), 4, 1'b0,
                mk_commit(32'hbfc00380, 1'b1, 32'h80002000, 5'h04, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3)};
    vecs[2] = '{"eret",     mk_trap(32'h0e, 32'h80003000, 32'h80003333, 1'b0, 32'h55, 0), 0, 1'b0,
                mk_commit(32'h80003000, 1'b0, 32'h0, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0)};
    vecs[3] = '{"ades",     mk_trap(32'h05, 32'hbfc00380, 32'h80004008, 1'b0, 32'h80004001, 2), 2, 1'b0,
                mk_commit(32'hbfc00380, 1'b1, 32'h80004008, 5'h05, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80004001)};
    vecs[4] = '{"int_wrap", mk_trap(32'h01, 32'hbfc00380, 32'h00000000, 1'b1, 32'h9, 1), 1, 1'b0,
                mk_commit(32'hbfc00380, 1'b1, 32'hfffffffc, 5'h01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0)};
    vecs[5] = '{"ov_edge",  mk_trap(32'h0c, 32'hbfc00380, 32'h80005010, 1'b0, 32'h0, 16), 16, 1'b0,
                mk_commit(32'hbfc00380, 1'b1, 32'h80005010, 5'h0c, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0)};
    vecs[6] = '{"bp_force", mk_trap(32'h09, 32'hbfc00380, 32'h80006000, 1'b0, 32'h0, 40), 16, 1'b1,
                mk_commit(32'hbfc00380, 1'b1, 32'h80006000, 5'h09, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0)};

    rst = 1'b1;  exc_valid = 1'b0;  exc_type = '0;  exc_target = '0;  exc_pc = '0;
    exc_in_ds = 1'b0;  exc_badvaddr = '0;  mem_busy = 1'b0;
    #1 check("reset", 0, got(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    idle_cycles(3, "idle_type0");

    // Directed table, excluding the forced-commit row
    for (int i = 0; i < 6; i++) begin
      run_trap(vecs[i].tr, vecs[i].commit, vecs[i].stall, vecs[i].forced, 1'b0, vecs[i].name);
      idle_cycles(1, "gap");
    end

    // Randomized traps against the schedule model
    for (int i = 0; i < 40; i++) begin
      trap_t t;
      int    len;
      len = $urandom_range(0, 15);
      t = mk_trap(types[$urandom_range(0, 7)], $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, len);
      run_trap(t, model_commit(t), (len > DRAIN_MAX) ? DRAIN_MAX : len, len > DRAIN_MAX, 1'b0, "rand");
      idle_cycles($urandom_range(0, 2), "rand_gap");
    end

    // Held request: ignored throughout RECOVER, re-accepted once IDLE
    run_trap(vecs[0].tr, vecs[0].commit, 0, 1'b0, 1'b1, "hold_first");
    run_trap(vecs[0].tr, vecs[0].commit, 0, 1'b0, 1'b0, "hold_again");

    // Forced commit, then stickiness of drain_timeout
    run_trap(vecs[6].tr, vecs[6].commit, vecs[6].stall, vecs[6].forced, 1'b0, vecs[6].name);
    idle_cycles(2, "sticky_idle");
    run_trap(vecs[3].tr, vecs[3].commit, vecs[3].stall, 1'b0, 1'b0, "sticky_trap");

    // Reset asserted mid-COMMIT clears everything asynchronously
    drive_trap(vecs[0].tr);
    mem_busy = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_commit", 0, got(), '{vecs[0].commit.stall, 1'b1, 1'b1, 32'hbfc00380, 1'b1, 32'h80001000,
          1'b1, 5'h08, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
    exc_valid = 1'b0;
    #2 rst = 1'b1;
    exp_timeout = 1'b0;
    #1 check("rst_in_commit", 0, got(), '0);
    @(negedge clk) rst = 1'b0;
    idle_cycles(2, "post_rst_idle");
    run_trap(vecs[2].tr, vecs[2].commit, 0, 1'b0, 1'b0, "post_rst_eret");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
